// File: rtl/ro_meas_ctrl_if.sv
// Request/result handshake between the characterisation logic (master)
// and the ring-oscillator measurement controller (slave).
interface ro_meas_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             ovf;

    modport master (
        output start, abort,
        input  busy, done, count, ovf
    );

    modport slave (
        input  start, abort,
        output busy, done, count, ovf
    );
endinterface

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement controller: enables the ring, lets it settle,
// counts synchronized rising edges of ro_in over a fixed window of clk cycles
// and reports a saturating count with a start/done handshake.
module ro_meas_ctrl #(
    parameter int WIN_CYCLES    = 1000,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ro_in,
    output logic                ro_en,
    ro_meas_ctrl_if.slave       bus
);
    localparam int MAXC  = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W = $clog2(MAXC + 1);

    localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_GATE   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    // [0],[1] synchronize ro_in; [2] holds the previous synchronized value
    logic [2:0]       sync_q;
    logic             rise;

    // Count stays pinned at all-ones once reached
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign rise = sync_q[1] & ~sync_q[2];

    // Synchronizer and edge-detect flops run continuously, independent of state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 3'b000;
        else     sync_q <= {sync_q[1:0], ro_in};
    end

    // State, timer and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state, timer and counting logic; abort wins over timer expiry
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SETTLE;
                    timer_d = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (timer_q == SET_LAST) begin
                    state_d = S_GATE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GATE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    if (rise) begin
                        count_d = sat_inc(count_q);
                        if (count_q == CNT_MAX) ovf_d = 1'b1;
                    end
                    if (timer_q == WIN_LAST) begin
                        state_d = S_DONE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so reset clears them at once
    always_comb begin
        ro_en     = (state_q == S_SETTLE) || (state_q == S_GATE);
        bus.busy  = (state_q != S_IDLE);
        bus.done  = (state_q == S_DONE);
        bus.count = count_q;
        bus.ovf   = ovf_q;
    end
endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench: main instance (CNT_W=16, ro period 10 clk) and a narrow
// instance (CNT_W=4, ro period 4 clk) driven in lockstep.
module tb_ro_meas_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic ro_a, ro_b;
    logic ro_en_a, ro_en_b;
    int   ro_half;
    logic ro_static;

    int checks = 0;
    int errors = 0;

    ro_meas_ctrl_if #(.CNT_W(16)) ifa ();
    ro_meas_ctrl_if #(.CNT_W(4))  ifb ();

    ro_meas_ctrl #(.WIN_CYCLES(100), .SETTLE_CYCLES(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .ro_in(ro_a), .ro_en(ro_en_a), .bus(ifa)
    );
    ro_meas_ctrl #(.WIN_CYCLES(100), .SETTLE_CYCLES(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .ro_in(ro_b), .ro_en(ro_en_b), .bus(ifb)
    );

    always #5 clk = ~clk;

    // Ring A: half-period ro_half clk cycles, or static level when ro_half==0
    initial begin
        ro_a = 1'b0;
        #3;
        forever begin
            if (ro_half == 0) begin
                ro_a = ro_static;
                #10;
            end else begin
                #(ro_half * 10);
                ro_a = ~ro_a;
            end
        end
    end

    // Ring B: period 4 clk cycles
    initial begin
        ro_b = 1'b0;
        #7;
        forever begin
            #20;
            ro_b = ~ro_b;
        end
    end

    // Results of run_meas
    int          start_mode;
    int          abort_at;
    int          en_n, done_n, done_first, done_last, idle_n, busy_fall;
    logic [31:0] cnta_done, ovfa_done, cntb_done, ovfb_done;
    logic [31:0] ab_busy, ab_en, ab_cnta, ab_cntb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic a);
        ifa.start = s;
        ifb.start = s;
        ifa.abort = a;
        ifb.abort = a;
    endtask

    // Sample index i is taken 1 time unit after edge t0+i, where t0 is the
    // edge that accepted the start driven just before the call.
    task automatic run_meas(input int ncyc);
        logic s;
        en_n = 0; done_n = 0; done_first = -1; done_last = -1;
        idle_n = 0; busy_fall = -1;
        cnta_done = '0; ovfa_done = '0; cntb_done = '0; ovfb_done = '0;
        ab_busy = 'x; ab_en = 'x; ab_cnta = 'x; ab_cntb = 'x;
        for (int i = 0; i < ncyc; i++) begin
            if (ro_en_a) en_n++;
            if (!ifa.busy) idle_n++;
            if (ifa.done) begin
                done_n++;
                if (done_first < 0) done_first = i;
                done_last = i;
                cnta_done = 32'(ifa.count);
                ovfa_done = 32'(ifa.ovf);
                cntb_done = 32'(ifb.count);
                ovfb_done = 32'(ifb.ovf);
            end
            if (done_first >= 0 && busy_fall < 0 && !ifa.busy) busy_fall = i;
            if (i == abort_at + 1) begin
                ab_busy = 32'(ifa.busy);
                ab_en   = 32'(ro_en_a);
                ab_cnta = 32'(ifa.count);
                ab_cntb = 32'(ifb.count);
            end
            case (start_mode)
                1:       s = (i == 28) || (i == 68);
                2:       s = 1'b1;
                default: s = 1'b0;
            endcase
            set_in(s, i == abort_at);
            tick(1);
        end
    endtask

    task automatic start_pulse();
        set_in(1'b1, 1'b0);
        tick(1);
    endtask

    initial begin
        rst = 1'b1;
        ro_half = 5;
        ro_static = 1'b0;
        start_mode = 0;
        abort_at = -10;
        set_in(1'b0, 1'b0);
        tick(3);

        // Reset values
        chk("rst_busy", 32'(ifa.busy), 0);
        chk("rst_ro_en", 32'(ro_en_a), 0);
        chk("rst_done", 32'(ifa.done), 0);
        chk("rst_count", 32'(ifa.count), 0);
        chk("rst_ovf", 32'(ifa.ovf), 0);
        rst = 1'b0;
        tick(3);
        chk("idle_busy", 32'(ifa.busy), 0);

        // Basic measurement plus saturation on the narrow instance
        start_pulse();
        chk("basic_busy_t0", 32'(ifa.busy), 1);
        chk("basic_en_t0", 32'(ro_en_a), 1);
        run_meas(200);
        chk("basic_en_cycles", en_n, 108);
        chk("basic_done_n", done_n, 1);
        chk("basic_done_at", done_first, 108);
        chk("basic_busy_fall", busy_fall, 109);
        chk("basic_count_range", 32'((cnta_done >= 9) && (cnta_done <= 11)), 1);
        chk("basic_ovf", ovfa_done, 0);
        chk("sat_count", cntb_done, 15);
        chk("sat_ovf", ovfb_done, 1);
        chk("basic_count_hold", 32'(ifa.count), cnta_done);
        chk("sat_count_hold", 32'(ifb.count), 15);
        chk("sat_ovf_hold", 32'(ifb.ovf), 1);

        // Static high input
        ro_half = 0;
        ro_static = 1'b1;
        tick(12);
        start_pulse();
        chk("sat_cleared_cnt", 32'(ifb.count), 0);
        chk("sat_cleared_ovf", 32'(ifb.ovf), 0);
        run_meas(120);
        chk("static1_done_n", done_n, 1);
        chk("static1_count", cnta_done, 0);

        // Static low input
        ro_static = 1'b0;
        tick(5);
        start_pulse();
        run_meas(120);
        chk("static0_done_n", done_n, 1);
        chk("static0_count", cnta_done, 0);

        // Start pulses during GATE are ignored
        ro_half = 5;
        tick(12);
        start_mode = 1;
        start_pulse();
        run_meas(150);
        chk("busy_start_done_n", done_n, 1);
        chk("busy_start_done_at", done_first, 108);

        // Held start: back-to-back runs with one IDLE cycle between
        start_mode = 2;
        start_pulse();
        run_meas(230);
        chk("held_done_n", done_n, 2);
        chk("held_done_first", done_first, 108);
        chk("held_done_last", done_last, 218);
        chk("held_idle_cycles", idle_n, 2);
        set_in(1'b0, 1'b1);
        tick(1);
        set_in(1'b0, 1'b0);
        chk("held_abort_busy", 32'(ifa.busy), 0);
        start_mode = 0;
        tick(3);

        // Abort at GATE cycle 50
        abort_at = 58;
        start_pulse();
        run_meas(140);
        chk("abort_done_n", done_n, 0);
        chk("abort_busy", ab_busy, 0);
        chk("abort_en", ab_en, 0);
        chk("abort_count", ab_cnta, 0);
        chk("abort_count_b", ab_cntb, 0);

        // Abort coincident with window expiry
        abort_at = 107;
        start_pulse();
        run_meas(130);
        chk("abort_exp_done_n", done_n, 0);
        chk("abort_exp_busy", ab_busy, 0);
        abort_at = -10;

        // Asynchronous reset mid-SETTLE
        start_pulse();
        set_in(1'b0, 1'b0);
        tick(3);
        #4 rst = 1'b1;
        #1;
        chk("arst_settle_busy", 32'(ifa.busy), 0);
        chk("arst_settle_en", 32'(ro_en_a), 0);
        #2 rst = 1'b0;
        tick(2);
        chk("arst_settle_idle", 32'(ifa.busy), 0);

        // Asynchronous reset mid-GATE
        start_pulse();
        set_in(1'b0, 1'b0);
        tick(50);
        chk("arst_gate_precount", 32'(ifa.count != 0), 1);
        #4 rst = 1'b1;
        #1;
        chk("arst_gate_busy", 32'(ifa.busy), 0);
        chk("arst_gate_en", 32'(ro_en_a | ro_en_b), 0);
        chk("arst_gate_count", 32'(ifa.count), 0);
        chk("arst_gate_done", 32'(ifa.done), 0);
        #2 rst = 1'b0;
        tick(2);

        // Measurement after reset
        start_pulse();
        run_meas(150);
        chk("post_rst_done_n", done_n, 1);
        chk("post_rst_done_at", done_first, 108);
        chk("post_rst_count_range", 32'((cnta_done >= 9) && (cnta_done <= 11)), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ro_meas_ctrl.md
# ro_meas_ctrl

Measurement controller for an on-chip ring oscillator built from a chain of inverter cells. The block enables the oscillator, waits for it to settle, counts oscillator rising edges over a fixed window of system-clock cycles, and reports the count with a start/done handshake. It sits between the test/characterisation logic and the inverter ring, and it is the only block that drives the ring's enable.

## Interface

Parameters:
- `WIN_CYCLES`, default 1000: gate-window length in `clk` cycles; must be ≥ 1.
- `SETTLE_CYCLES`, default 8: cycles between enabling the ring and opening the window; must be ≥ 3 so that stale synchronizer contents are flushed.
- `CNT_W`, default 16: width of the edge counter and of `count`.

Ports:
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a measurement; sampled only in IDLE.
- `abort` in 1: cancel a measurement in progress; sampled in SETTLE and GATE.
- `ro_in` in 1: ring-oscillator output; asynchronous to `clk`.
- `ro_en` out 1: ring enable, which drives the ring's NAND/inverter gate input.
- `busy` out 1: measurement in progress.
- `done` out 1: one-cycle pulse; `count` and `ovf` are valid.
- `count` out `CNT_W`: rising edges counted in the last window.
- `ovf` out 1: the count saturated during the last window.

## Operation

FSM states: IDLE, SETTLE, GATE, DONE.

- **IDLE**: `ro_en`=0, `busy`=0. If `start`=1, go to SETTLE. On that transition, clear `count`, `ovf`, and the cycle timer.
- **SETTLE**: `ro_en`=1, `busy`=1. The timer counts `SETTLE_CYCLES` cycles, then the FSM goes to GATE and the timer clears. No edges are counted.
- **GATE**: `ro_en`=1, `busy`=1. Each synchronized rising edge of `ro_in` increments `count`. After `WIN_CYCLES` cycles the FSM goes to DONE.
- **DONE**: `ro_en`=0, `busy`=1, `done`=1 for exactly one cycle. The FSM then returns to IDLE.

Abort handling:
- `abort`=1 in SETTLE or GATE moves the FSM to IDLE on the next edge.
- `ro_en` drops, `done` does not pulse, and `count` and `ovf` are cleared to 0.
- `abort` has priority over the timer expiring in the same cycle.
- `abort` has no effect in IDLE or DONE.

Edge detection:
- `ro_in` passes through a 2-flop synchronizer, followed by a third flop for edge detection.
- A rising edge is synchronized-current=1 with previous=0.
- All three flops run continuously.

Arithmetic:
- `count` saturates at 2^`CNT_W`−1.
- An edge detected while `count` is already at the maximum sets `ovf`=1, and `ovf` stays set until the next start.
- The timer width is sized to max(`WIN_CYCLES`, `SETTLE_CYCLES`).

Other rules:
- `start` is ignored while `busy`=1. A held-high `start` re-triggers one cycle after DONE, from IDLE.
- `count` and `ovf` hold their values after DONE until the next accepted start or abort.
- Measurable `ro_in` frequency is below f_clk/2. Faster inputs alias, and that is a usage constraint, not an error the block detects.

## Timing

Reset values (all applied asynchronously on `rst`=1):
- State = IDLE.
- `ro_en`=0, `busy`=0, `done`=0, `count`=0, `ovf`=0.
- Synchronizer and timer = 0.

Start-to-done timing:
- If `start` is sampled high at edge t0, then `ro_en` and `busy` are high after t0.
- The FSM enters GATE at t0+`SETTLE_CYCLES`.
- `done` is high in the cycle after t0+`SETTLE_CYCLES`+`WIN_CYCLES`, and `ro_en` is low in that same cycle.
- `busy` falls one cycle after `done`.

Counting window:
- Edges are counted from the synchronizer output. The counting window is therefore the GATE interval delayed by 2 `clk` cycles in `ro_in` time, and the count error is ±1.

Reset during operation:
- `rst` in any state returns the block to the reset values immediately. No `done` pulse is produced.

## Test plan

All scenarios use `WIN_CYCLES`=100, `SETTLE_CYCLES`=8, `CNT_W`=16 unless stated otherwise.

- **Basic measurement**: `ro_in` toggles every 5 `clk` cycles (period 10), one `start` pulse → `ro_en` is high for 108 cycles, `done` pulses once, `count`=10±1, `ovf`=0.
- **Saturation** (`CNT_W`=4): `ro_in` period 4 cycles, start → `count`=15 and `ovf`=1 at `done`; both stay at those values until the next start.
- **Static input**: `ro_in` held at 1 (and held at 0 in a second run), start → `count`=0 at `done`.
- **Start while busy**: pulse `start` at cycles 20 and 60 of GATE → exactly one `done`, and the timing is unchanged. Holding `start` high continuously → back-to-back measurements separated by one IDLE cycle.
- **Abort** during GATE cycle 50 → next cycle state is IDLE, `ro_en`=0, `count`=0, and no `done` pulse. Abort in the same cycle the timer expires → no `done` pulse.
- **Asynchronous reset**: assert `rst` mid-SETTLE and again mid-GATE, between clock edges → all outputs are 0 before the next `clk` edge. A subsequent start measures correctly.
